dot_product_sequencer: RTL and testbench

Sequential dot-product stage wrapped around the shift-add `Multiplier`. It accepts a stream of unsigned operand pairs over a valid/ready handshake and drives each pair through the multiplier's Start/Ready handshake. It accumulates the products into a wide register and presents the final sum when the pair flagged last has been accumulated. The block sits between an operand source and the multiplier, and consumes the multiplier's `Product`/`Ready`.

---
 rtl/dot_product_sequencer.sv | 128 ++++++++++++
 tb/tb_dot_product_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
// Streams unsigned operand pairs through an external shift-add multiplier
// (Start/Ready handshake) and accumulates the products into a wide sum.
// The sum is presented with SumValid once the pair flagged last has been
// accumulated, and held until SumAck.
// Optional feature: define DOT_PRODUCT_SATURATE_EN to saturate the
// accumulator at all ones instead of wrapping on carry-out.
// ACC_WIDTH must be at least 2*DATA_WIDTH.

module dot_product_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [DATA_WIDTH-1:0]   InA,
    input  logic [DATA_WIDTH-1:0]   InB,
    input  logic                    InValid,
    input  logic                    InLast,
    output logic                    InReady,
    output logic [DATA_WIDTH-1:0]   MulA,
    output logic [DATA_WIDTH-1:0]   MulB,
    output logic                    MulStart,
    input  logic [2*DATA_WIDTH-1:0] MulProduct,
    input  logic                    MulReady,
    output logic [ACC_WIDTH-1:0]    Sum,
    output logic                    SumValid,
    input  logic                    SumAck,
    output logic [15:0]             Count,
    output logic                    Overflow
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACC,
        DONE
    } state_t;

    state_t                 state;
    logic                   last_q;
    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     sum_ext;
    logic                   carry;

    // Accumulator adder with one extra bit to expose the carry out.
    assign prod_ext = (ACC_WIDTH+1)'(MulProduct);
    assign sum_ext  = {1'b0, Sum} + prod_ext;
    assign carry    = sum_ext[ACC_WIDTH];

    // NOTE: InReady is combinational on MulReady so that after an abandoned
    // multiplication no pair is taken until the multiplier is idle again;
    // gating with Reset keeps it low while reset is held.
    assign InReady = (state == IDLE) && MulReady && !Reset;

    // Main sequencer: handshake with the source, drive the multiplier,
    // accumulate, and hold the final sum until acknowledged.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            last_q   <= 1'b0;
            MulA     <= '0;
            MulB     <= '0;
            MulStart <= 1'b0;
            Sum      <= '0;
            SumValid <= 1'b0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && InReady) begin
                        MulA     <= InA;
                        MulB     <= InB;
                        last_q   <= InLast;
                        MulStart <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    // Hold Start until the multiplier shows it has begun.
                    if (!MulReady) begin
                        MulStart <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (MulReady) begin
                        state <= ACC;
                    end
                end
                ACC: begin
`ifdef DOT_PRODUCT_SATURATE_EN
                    Sum <= carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
                    Sum <= sum_ext[ACC_WIDTH-1:0];
`endif
                    if (Count != 16'hFFFF) begin
                        Count <= Count + 16'd1;
                    end
                    Overflow <= Overflow | carry;
                    if (last_q) begin
                        SumValid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (SumAck) begin
                        Sum      <= '0;
                        Count    <= '0;
                        Overflow <= 1'b0;
                        SumValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer
// Self-checking bench: directed vectors from the test plan followed by
// randomized vectors, with a behavioural multiplier of random busy time and
// a reference model that folds the accepted products arithmetically.

module tb_dot_product_sequencer;

    localparam int DW = 16;
    localparam int AW = 32;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [DW-1:0]   InA, InB;
    logic            InValid, InLast;
    logic            InReady;
    logic [DW-1:0]   MulA, MulB;
    logic            MulStart;
    logic [2*DW-1:0] MulProduct = '0;
    logic            MulReady = 1'b1;
    logic [AW-1:0]   Sum;
    logic            SumValid;
    logic            SumAck;
    logic [15:0]     Count;
    logic            Overflow;

    int n_vec = 0;
    int n_err = 0;

    int unsigned va[$];
    int unsigned vb[$];
    int          mul_lat = 2;

    dot_product_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InA        (InA),
        .InB        (InB),
        .InValid    (InValid),
        .InLast     (InLast),
        .InReady    (InReady),
        .MulA       (MulA),
        .MulB       (MulB),
        .MulStart   (MulStart),
        .MulProduct (MulProduct),
        .MulReady   (MulReady),
        .Sum        (Sum),
        .SumValid   (SumValid),
        .SumAck     (SumAck),
        .Count      (Count),
        .Overflow   (Overflow)
    );

    always #5 Clk = ~Clk;

    // Behavioural multiplier: takes operands on Start while idle, stays busy
    // for mul_lat cycles, then raises Ready with the product. Not reset.
    logic [DW-1:0] m_a, m_b;
    int            m_cnt;
    always @(posedge Clk) begin
        if (!MulReady) begin
            if (m_cnt <= 1) begin
                MulReady   <= 1'b1;
                MulProduct <= m_a * m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (MulStart) begin
            MulReady <= 1'b0;
            m_cnt    <= mul_lat;
            m_a      <= MulA;
            m_b      <= MulB;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: fold the vector's products with plain arithmetic.
    function automatic void ref_model(output longint unsigned s, output bit ov);
        longint unsigned lim = 64'd1 << AW;
        s  = 0;
        ov = 1'b0;
        foreach (va[i]) begin
            s = s + longint'(va[i]) * longint'(vb[i]);
            if (s >= lim) begin
                ov = 1'b1;
`ifdef DOT_PRODUCT_SATURATE_EN
                s = lim - 1;
`else
                s = s - lim;
`endif
            end
        end
    endfunction

    // Offer one pair; while InReady is low, present junk (optionally with
    // InValid high) that must be ignored. Starts and ends at a negedge.
    task automatic send_pair(input int unsigned a, input int unsigned b,
                             input bit last, input bit junk);
        int guard = 0;
        mul_lat = $urandom_range(1, 6);
        forever begin
            if (InReady) begin
                InValid = 1'b1;
                InA     = DW'(a);
                InB     = DW'(b);
                InLast  = last;
                @(posedge Clk);
                break;
            end
            InValid = junk;
            InA     = DW'($urandom);
            InB     = DW'($urandom);
            InLast  = 1'($urandom);
            guard++;
            if (guard > 300) begin
                check("accept_timeout", 64'(InReady), 64'd1);
                return;
            end
            @(negedge Clk);
        end
        @(negedge Clk);
        InValid = 1'b0;
        check("inready_busy", 64'(InReady), 64'd0);
    endtask

    // Run the vector held in va/vb, then check result, hold and ack.
    task automatic run_vector(input bit stall, input int hold, input bit early_ack);
        longint unsigned es;
        bit              eo;
        int              guard = 0;
        int              n = va.size();
        for (int i = 0; i < n; i++) begin
            send_pair(va[i], vb[i], i == n - 1, stall);
            if (stall) begin
                int gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    InValid = 1'b0;
                    InA     = DW'($urandom);
                    InB     = DW'($urandom);
                    @(negedge Clk);
                end
            end
        end
        SumAck = early_ack;
        while (!SumValid && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        SumAck = 1'b0;
        check("sumvalid", 64'(SumValid), 64'd1);
        ref_model(es, eo);
        check("sum", 64'(Sum), es);
        check("count", 64'(Count), 64'(n));
        check("overflow", 64'(Overflow), 64'(eo));
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            check("hold_sum", 64'(Sum), es);
            check("hold_valid", 64'(SumValid), 64'd1);
            check("hold_inready", 64'(InReady), 64'd0);
        end
        SumAck = 1'b1;
        @(negedge Clk);
        SumAck = 1'b0;
        check("ack_sum", 64'(Sum), 64'd0);
        check("ack_count", 64'(Count), 64'd0);
        check("ack_valid", 64'(SumValid), 64'd0);
        check("ack_overflow", 64'(Overflow), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_inready", 64'(InReady), 64'd0);
        check("rst_mula", 64'(MulA), 64'd0);
        check("rst_mulb", 64'(MulB), 64'd0);
        check("rst_mulstart", 64'(MulStart), 64'd0);
        check("rst_sum", 64'(Sum), 64'd0);
        check("rst_sumvalid", 64'(SumValid), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        check("rst_overflow", 64'(Overflow), 64'd0);
    endtask

    initial begin
        int guard;
        Reset   = 1'b1;
        InA     = '0;
        InB     = '0;
        InValid = 1'b0;
        InLast  = 1'b0;
        SumAck  = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_outputs();
        Reset = 1'b0;
        @(negedge Clk);

        // Single term.
        va = '{4};  vb = '{5};
        run_vector(1'b0, 0, 1'b0);

        // Three terms with ack back-pressure of 10 cycles.
        va = '{1, 3, 5};  vb = '{2, 4, 6};
        run_vector(1'b0, 10, 1'b0);

        // Overflow at 32 bits.
        va = '{65535, 65535};  vb = '{65535, 65535};
        run_vector(1'b0, 1, 1'b0);

        // Input stall with junk data and ignored InValid.
        va = '{9, 100, 7};  vb = '{11, 3, 250};
        run_vector(1'b1, 0, 1'b0);

        // Ack asserted on the rising edge of SumValid must be ignored.
        va = '{12, 13};  vb = '{14, 15};
        run_vector(1'b0, 1, 1'b1);

        // Reset while the second term is in the multiplier.
        send_pair(10, 11, 1'b0, 1'b0);
        send_pair(12, 13, 1'b0, 1'b0);
        mul_lat = 8;
        guard = 0;
        while (!(MulReady == 1'b0 && MulStart == 1'b0) && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        check("reach_wait", 64'(MulReady), 64'd0);
        Reset = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("post_rst_inready", 64'(InReady), 64'd0);
        @(negedge Clk);
        va = '{7};  vb = '{8};
        run_vector(1'b0, 0, 1'b0);

        // Randomized vectors.
        for (int v = 0; v < 25; v++) begin
            int n = $urandom_range(1, 5);
            bit big = 1'($urandom);
            va.delete();
            vb.delete();
            for (int i = 0; i < n; i++) begin
                va.push_back(big ? $urandom_range(0, 65535) : $urandom_range(0, 255));
                vb.push_back(big ? $urandom_range(0, 65535) : $urandom_range(0, 255));
            end
            run_vector(1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
